// File: rtl/wb_pkg.sv
// Shared writeback definitions: default widths, request record, zero-register index.
package wb_pkg;

  localparam int unsigned WB_REG_W  = 5;
  localparam int unsigned WB_DATA_W = 32;

  localparam logic [WB_REG_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [WB_REG_W-1:0]  reg_idx;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_defer_fifo.sv
// In-order deferral FIFO for ALU writebacks that lost the write port.
// Overflowing pushes and underflowing pops are ignored.
module wb_defer_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type req_t = wb_req_t,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  req_t          push_req,
  input  logic          pop,
  output req_t          head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  req_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage array: data only, validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_req;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks push minus pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between load returns (never stalled)
// and ALU results (stallable, deferred in order through wb_defer_fifo).
// Optional build macro WB_CONFLICT_CNT_EN adds io_conflict_count.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = WB_DATA_W,
  parameter int unsigned REG_W  = WB_REG_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       io_alu_valid,
  output logic                       io_alu_ready,
  input  logic [REG_W-1:0]           io_alu_reg,
  input  logic [DATA_W-1:0]          io_alu_data,
  input  logic                       io_mem_valid,
  input  logic [REG_W-1:0]           io_mem_reg,
  input  logic [DATA_W-1:0]          io_mem_data,
  output logic                       io_write,
  output logic [REG_W-1:0]           io_write_reg,
  output logic [DATA_W-1:0]          io_write_data,
  output logic [$clog2(DEPTH):0]     io_pending,
  output logic                       io_busy
`ifdef WB_CONFLICT_CNT_EN
  ,
  output logic [31:0]                io_conflict_count
`endif
);

  typedef struct packed {
    logic [REG_W-1:0]  reg_idx;
    logic [DATA_W-1:0] data;
  } req_t;

  localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(ZERO_REG);

  req_t alu_req;
  req_t head;
  logic full;
  logic empty;
  logic alu_acc;
  logic alu_nz;
  logic mem_sel;
  logic fifo_sel;
  logic direct_sel;
  logic push;

  assign alu_req      = '{reg_idx: io_alu_reg, data: io_alu_data};
  assign io_alu_ready = !full;
  assign io_busy      = !empty;

  wb_defer_fifo #(
    .DEPTH (DEPTH),
    .req_t (req_t)
  ) u_fifo (
    .clk      (clock),
    .rst_n    (reset),
    .push     (push),
    .push_req (alu_req),
    .pop      (fifo_sel),
    .head     (head),
    .count    (io_pending),
    .full     (full),
    .empty    (empty)
  );

  // Priority select: load, then oldest deferred ALU write, then direct ALU write.
  // Register-0 ALU requests are accepted but neither pushed nor issued.
  always_comb begin
    alu_acc    = io_alu_valid && !full;
    alu_nz     = (io_alu_reg != ZERO_IDX);
    mem_sel    = io_mem_valid && (io_mem_reg != ZERO_IDX);
    fifo_sel   = !mem_sel && !empty;
    direct_sel = !mem_sel && empty && alu_acc && alu_nz;
    push       = alu_acc && alu_nz && (mem_sel || !empty);
  end

  // Registered write port; index and data hold when no write is issued.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_write      <= 1'b0;
      io_write_reg  <= '0;
      io_write_data <= '0;
    end else begin
      io_write <= mem_sel || fifo_sel || direct_sel;
      if (mem_sel) begin
        io_write_reg  <= io_mem_reg;
        io_write_data <= io_mem_data;
      end else if (fifo_sel) begin
        io_write_reg  <= head.reg_idx;
        io_write_data <= head.data;
      end else if (direct_sel) begin
        io_write_reg  <= io_alu_reg;
        io_write_data <= io_alu_data;
      end
    end
  end

`ifdef WB_CONFLICT_CNT_EN
  // Counts ALU writes deferred by a load or by older queued entries.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) io_conflict_count <= '0;
    else if (push) io_conflict_count <= io_conflict_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a queue-based reference model predicts
// each cycle's write; a separate monitor compares it one cycle later.
module tb_wb_port_arbiter;

  localparam int unsigned DEPTH = 4;

  logic        clock;
  logic        reset;
  logic        io_alu_valid;
  logic        io_alu_ready;
  logic [4:0]  io_alu_reg;
  logic [31:0] io_alu_data;
  logic        io_mem_valid;
  logic [4:0]  io_mem_reg;
  logic [31:0] io_mem_data;
  logic        io_write;
  logic [4:0]  io_write_reg;
  logic [31:0] io_write_data;
  logic [2:0]  io_pending;
  logic        io_busy;
`ifdef WB_CONFLICT_CNT_EN
  logic [31:0] io_conflict_count;
  int unsigned conf_model;
`endif

  wb_port_arbiter #(
    .DEPTH  (DEPTH),
    .DATA_W (32),
    .REG_W  (5)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .io_alu_valid  (io_alu_valid),
    .io_alu_ready  (io_alu_ready),
    .io_alu_reg    (io_alu_reg),
    .io_alu_data   (io_alu_data),
    .io_mem_valid  (io_mem_valid),
    .io_mem_reg    (io_mem_reg),
    .io_mem_data   (io_mem_data),
    .io_write      (io_write),
    .io_write_reg  (io_write_reg),
    .io_write_data (io_write_data),
    .io_pending    (io_pending),
    .io_busy       (io_busy)
`ifdef WB_CONFLICT_CNT_EN
    ,
    .io_conflict_count (io_conflict_count)
`endif
  );

  typedef struct {
    bit          w;
    logic [4:0]  r;
    logic [31:0] d;
  } exp_t;

  exp_t        expq[$];   // predicted write-port state, one entry per cycle
  exp_t        dq[$];     // model of deferred ALU writes, oldest first
  logic [4:0]  last_r;
  logic [31:0] last_d;
  bit          in_rst;
  int          checks;
  int          errors;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, want);
    end
  endtask

  // One clock of stimulus: check registered status, then predict this cycle's write.
  task automatic cycle(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                       input bit mv, input logic [4:0] mr, input logic [31:0] md);
    exp_t e;
    bit   ready_e;
    bit   acc;
    bit   pushed;
    @(posedge clock);
    #2;
    io_alu_valid = av; io_alu_reg = ar; io_alu_data = ad;
    io_mem_valid = mv; io_mem_reg = mr; io_mem_data = md;
    ready_e = (dq.size() < DEPTH);
    chk("alu_ready", io_alu_ready, ready_e);
    chk("pending", io_pending, dq.size());
    chk("busy", io_busy, dq.size() != 0);
`ifdef WB_CONFLICT_CNT_EN
    chk("conflict_count", io_conflict_count, conf_model);
`endif
    acc    = av && ready_e;
    pushed = 0;
    e.w = 0; e.r = last_r; e.d = last_d;
    if (mv && mr != 0) begin
      e = '{1'b1, mr, md};
      if (acc && ar != 0) pushed = 1;
    end else if (dq.size() != 0) begin
      e = dq.pop_front();
      if (acc && ar != 0) pushed = 1;
    end else if (acc && ar != 0) begin
      e = '{1'b1, ar, ad};
    end
    if (pushed) begin
      dq.push_back('{1'b1, ar, ad});
`ifdef WB_CONFLICT_CNT_EN
      conf_model++;
`endif
    end
    if (e.w) begin
      last_r = e.r;
      last_d = e.d;
    end
    expq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
  endtask

  // Mid-cycle asynchronous reset: outputs must clear without waiting for a clock.
  task automatic do_reset_midcycle();
    @(posedge clock);
    #5;
    in_rst = 1;
    reset  = 1'b0;
    #1;
    chk("rst_write", io_write, 1'b0);
    chk("rst_write_reg", io_write_reg, 5'd0);
    chk("rst_write_data", io_write_data, 32'd0);
    chk("rst_pending", io_pending, 3'd0);
    chk("rst_busy", io_busy, 1'b0);
    chk("rst_ready", io_alu_ready, 1'b1);
    io_alu_valid = 0; io_mem_valid = 0;
    expq.delete();
    dq.delete();
    last_r = '0; last_d = '0;
`ifdef WB_CONFLICT_CNT_EN
    conf_model = 0;
`endif
    repeat (2) @(posedge clock);
    #5;
    reset  = 1'b1;
    in_rst = 0;
  endtask

  // Monitor: one cycle after each prediction, compare the registered write port.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (!reset || in_rst) continue;
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("write", io_write, e.w);
        chk("write_reg", io_write_reg, e.r);
        chk("write_data", io_write_data, e.d);
      end else begin
        chk("write_idle", io_write, 1'b0);
      end
    end
  end

  initial begin
    checks = 0; errors = 0; in_rst = 0;
    last_r = '0; last_d = '0;
`ifdef WB_CONFLICT_CNT_EN
    conf_model = 0;
`endif
    io_alu_valid = 0; io_alu_reg = '0; io_alu_data = '0;
    io_mem_valid = 0; io_mem_reg = '0; io_mem_data = '0;
    reset = 1'b0;
    #1;
    chk("por_write", io_write, 1'b0);
    chk("por_pending", io_pending, 3'd0);
    repeat (2) @(posedge clock);
    #5 reset = 1'b1;

    // Direct ALU write.
    cycle(1, 5'd3, 32'h11, 0, 5'd0, 32'd0);
    idle(1);

    // Load and ALU collide: load first, ALU deferred one cycle.
    cycle(1, 5'd6, 32'hBB, 1, 5'd5, 32'hAA);
    idle(3);

    // Four back-to-back loads fill the FIFO, then it drains in order.
    for (int i = 1; i <= 4; i++)
      cycle(1, 5'(i), 32'h100 + 32'(i), 1, 5'(i + 8), 32'h200 + 32'(i));
`ifdef WB_CONFLICT_CNT_EN
    chk("conflict_after_fill", 32'(dq.size()), 32'd4);
`endif
    cycle(1, 5'd7, 32'h77, 0, 5'd0, 32'd0);
    idle(6);

    // Register-0 writes from both sources are dropped.
    cycle(1, 5'd0, 32'hFF, 1, 5'd0, 32'hEE);
    idle(2);

    // Two deferred entries, then reset mid-cycle.
    cycle(1, 5'd10, 32'hA0, 1, 5'd11, 32'hB0);
    cycle(1, 5'd12, 32'hA1, 1, 5'd13, 32'hB1);
    do_reset_midcycle();
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) < 60, 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 99) < 35, 5'($urandom_range(0, 31)), $urandom);
    end

    // Drain with a bounded budget.
    for (int i = 0; i < 50 && dq.size() != 0; i++) idle(1);
    chk("drain_empty", dq.size(), 0);
    idle(2);
    @(posedge clock);
    #3;
    chk("scoreboard_empty", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two writeback sources.
  - ALU results: in order, stallable.
  - Memory load returns: arrive with variable delay, cannot be stalled.
- Sits between the execute/memory stages and the register file, and drives the write/write_reg/write_data triple that the writeback stage presents today.
- ALU results that lose a conflict are held in a small in-order FIFO and drained on free cycles.

Parameters:
- DEPTH, 4, ALU deferral FIFO entries (power of two, ≥2)
- DATA_W, 32, write data width
- REG_W, 5, register index width

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- io_alu_valid  in  1  ALU writeback request
- io_alu_ready  out  1  ALU request accepted this cycle
- io_alu_reg  in  REG_W  ALU destination register
- io_alu_data  in  DATA_W  ALU result
- io_mem_valid  in  1  load return (no backpressure)
- io_mem_reg  in  REG_W  load destination register
- io_mem_data  in  DATA_W  load data
- io_write  out  1  register-file write enable
- io_write_reg  out  REG_W  register-file write index
- io_write_data  out  DATA_W  register-file write data
- io_pending  out  $clog2(DEPTH)+1  FIFO occupancy
- io_busy  out  1  FIFO non-empty

Behaviour:
- Reset (reset low, async):
  - FIFO emptied, pointers and count = 0.
  - io_write=0, io_write_reg=0, io_write_data=0, io_pending=0, io_busy=0.
  - In-flight deferred writes are discarded.
- io_alu_ready = (count < DEPTH). It depends only on registered count, never on io_mem_valid.
- An ALU request is accepted when io_alu_valid && io_alu_ready.
- Writes to register 0 from either source are dropped: they take no FIFO slot and produce no write. A dropped ALU request still counts as accepted.
- Per-cycle selection, evaluated in priority order:
  1. mem_valid && mem_reg≠0: issue the load. An accepted ALU request is pushed.
  2. else if FIFO non-empty: issue the FIFO head and pop. An accepted ALU request is pushed the same cycle; count is unchanged.
  3. else if an ALU request is accepted: issue it directly, with no push.
  4. else: io_write=0 next cycle.
- Ordering: ALU writes never bypass older FIFO entries. A direct issue happens only when the FIFO is empty.
- Latency: the selected write appears on the io_write* outputs one cycle after selection (registered outputs). A direct ALU write therefore takes 1 cycle.
- When io_write=0, io_write_reg and io_write_data hold their previous values.
- Full FIFO:
  - ready=0, so no push.
  - A pop in the same cycle frees a slot visible the next cycle.
- Count arithmetic: count_next = count + push − pop, bounded to [0, DEPTH].
- Pointers wrap modulo DEPTH.
- A load return arriving on every cycle starves the FIFO. This is permitted; upstream guarantees gaps between loads.
- io_busy = (count≠0). The hazard unit uses it to block reads of pending destinations.

Optional Feature:
- Macro: WB_CONFLICT_CNT_EN.
- Defined:
  - Adds output io_conflict_count [31:0].
  - Increments by 1 on each cycle where an accepted ALU request (reg≠0) is pushed because of a load or a non-empty FIFO.
  - Wraps at 2^32; reset to 0.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package wb_pkg holds:
  - REG_W and DATA_W defaults
  - wb_req_t struct {reg, data}
  - a constant for the zero register index
- One sub-module, wb_defer_fifo: synchronous FIFO of wb_req_t with push, pop, count, full and empty, and async active-low reset.
- The top level holds the selection logic and the output registers.

Test Plan:
- Reset, then ALU valid, reg=3, data=0x11 with mem idle → next cycle write=1, reg=3, data=0x11; pending=0.
- Same cycle: mem reg=5, data=0xAA and ALU reg=6, data=0xBB → cycle+1 writes reg5/0xAA, cycle+2 writes reg6/0xBB; pending 1 then 0.
- Loads on 4 consecutive cycles with ALU valid each cycle (regs 1–4), DEPTH=4 → pending reaches 4, ready=0 on cycle 5; after the loads stop, FIFO drains regs 1,2,3,4 in order.
- ALU reg=0, data=0xFF and mem reg=0 → no write; pending unchanged; alu_ready stays 1.
- FIFO holding 2 entries, reset asserted low mid-cycle → outputs 0 immediately; after release, pending=0 and no stale writes issue.
- With WB_CONFLICT_CNT_EN, the scenario-3 stimulus → io_conflict_count=4.
